// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with valid/ready handshakes and divide-by-zero flag.
// Optional signed operation is enabled with DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic sgn_dvd, sgn_dvs;

  // Magnitudes of the incoming operands when signed mode is requested
  always_comb begin
    sgn_dvd = signed_mode & dividend[WIDTH-1];
    sgn_dvs = signed_mode & divisor[WIDTH-1];
    dvd_mag = sgn_dvd ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = sgn_dvs ? (~divisor + WIDTH'(1)) : divisor;
  end

  // Sign fixup of the final magnitude results
  always_comb begin
    q_fin = negq_q ? (~quo_nx + WIDTH'(1)) : quo_nx;
    r_fin = negr_q ? (~rem_nx + WIDTH'(1)) : rem_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    q_fin   = quo_nx;
    r_fin   = rem_nx;
  end
`endif

  // One restoring step: shift in next dividend bit, trial-subtract divisor
  always_comb begin
    rem_sh = {prem_q, dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    qbit   = ~diff[WIDTH];
    rem_nx = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {dvd_q[WIDTH-2:0], qbit};
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    negq_d      = negq_q;
    negr_d      = negr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          prem_d  = '0;
          if (divisor == '0) begin
            // Zero divisor spends a single CALC cycle to produce its result
            zero_d = 1'b1;
            cnt_d  = CW'(1);
            dvd_d  = dividend;
            dvs_d  = '0;
`ifdef DIVIDER_SIGNED_EN
            negq_d = 1'b0;
            negr_d = 1'b0;
`endif
          end else begin
            zero_d = 1'b0;
            cnt_d  = CW'(WIDTH);
            dvd_d  = dvd_mag;
            dvs_d  = dvs_mag;
`ifdef DIVIDER_SIGNED_EN
            negq_d = sgn_dvd ^ sgn_dvs;
            negr_d = sgn_dvd;
`endif
          end
        end
      end
      CALC: begin
        dvd_d  = quo_nx;
        prem_d = rem_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (zero_q) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
            dbz_d       = 1'b1;
          end else begin
            quotient_d  = q_fin;
            remainder_d = r_fin;
            dbz_d       = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32); signed cases need DIVIDER_SIGNED_EN.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic [31:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the language's own division operators
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    e.dbz = 1'b0;
    e.lat = 32'(W);
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 32'd1;
    end else begin
      e.q = a / b;
      e.r = a % b;
`ifdef DIVIDER_SIGNED_EN
      if (sm) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.q = 32'h8000_0000;
          e.r = '0;
        end else begin
          e.q = sa / sb;
          e.r = sa % sb;
        end
      end
`endif
    end
    return e;
  endfunction

  // Drive one division from a negedge, hold out_ready low for `hold` cycles, then handshake
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input int hold);
    exp_t e;
    int   lat;
    exp_q.push_back(model(a, b, sm));
    out_ready = (hold == 0);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    dividend    = $urandom;
    divisor     = $urandom;
    signed_mode = 1'($urandom);
    check("ov_early", 64'(out_valid), 64'd0);
    check("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    e = exp_q.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    check("quotient", 64'(quotient), 64'(e.q));
    check("remainder", 64'(remainder), 64'(e.r));
    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
    for (int i = 0; i < hold; i++) begin
      in_valid = (i < hold - 1);
      dividend = $urandom;
      divisor  = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_q", 64'(quotient), 64'(e.q));
      check("hold_r", 64'(remainder), 64'(e.r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ov_after_hs", 64'(out_valid), 64'd0);
    check("ir_after_hs", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    dividend    = '0;
    divisor     = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_div(32'd5, 32'd0, 1'b0, 0);
    run_div(32'd1000, 32'd10, 1'b0, 10);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_div(32'd0, 32'd3, 1'b0, 0);
    run_div(32'd3, 32'd7, 1'b0, 0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    // signed_mode is ignored (unsigned) unless the signed build is enabled
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
`ifdef DIVIDER_SIGNED_EN
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 2);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    run_div(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_div(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Abort a division with an asynchronous reset mid-calculation
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_quotient", 64'(quotient), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_stale_result", 64'(out_valid), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
